// File: rtl/fei4_rec_pkg.sv
// FE-I4 record header codes, service-record codes and the readout FSM state type.
// ST_SRV exists only when SERVICE_REC_EN is defined.
package fei4_rec_pkg;

    typedef logic [23:0] rec_t;

    localparam logic [7:0] HDR_DH = 8'hE9;
    localparam logic [7:0] HDR_AR = 8'hEA;
    localparam logic [7:0] HDR_VR = 8'hEC;
    localparam logic [7:0] HDR_SR = 8'hEF;

    localparam logic [5:0] SR_CODE_TRIG_DROP = 6'd14;

`ifdef SERVICE_REC_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HIT,
        ST_ADDR,
        ST_VAL,
        ST_SRV
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HIT,
        ST_ADDR,
        ST_VAL
    } state_e;
`endif

endpackage

// File: rtl/fei4_readout_arbiter_if.sv
// Output record stream: one registered 24-bit record with an empty flag and a pop strobe.
interface fei4_readout_arbiter_if;
    import fei4_rec_pkg::*;

    logic empty;
    rec_t data;
    logic read_fifo;

    modport master (
        output empty,
        output data,
        input  read_fifo
    );

    modport slave (
        input  empty,
        input  data,
        output read_fifo
    );

endinterface

// File: rtl/fei4_trig_queue.sv
// Pending-trigger FIFO holding {LV1ID, BCID}; a pop frees its slot for a push in the same cycle.
module fei4_trig_queue #(
    parameter int DEPTH = 16,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fei4_readout_arbiter.sv
// Arbitrates L1 events and RdReg readbacks onto one FE-I4 record stream.
// Define SERVICE_REC_EN to emit a trigger-drop service record after an event.
module fei4_readout_arbiter
    import fei4_rec_pkg::*;
#(
    parameter int TRIG_DEPTH = 16,
    parameter int MAX_HITS   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic        bcr,
    input  logic        ecr,
    input  logic        rd_req,
    input  logic [5:0]  rd_addr,
    input  logic [15:0] rd_data,
    input  logic [3:0]  cfg_hits_per_trig,
    input  logic [3:0]  cfg_tot,
    fei4_readout_arbiter_if.master rec,
    output logic [9:0]  trig_drop_cnt
);

    localparam logic [3:0] MAX_H = 4'(MAX_HITS);

    state_e      state_q;
    logic [9:0]  bcid_q;
    logic [4:0]  lv1_q;
    logic [9:0]  drop_q;
    logic [9:0]  drop_d;
    logic        valid_q;
    rec_t        data_q;
    logic        rd_pend_q;
    logic        last_rd_q;
    logic [5:0]  rd_addr_q;
    logic [15:0] rd_data_q;
    logic [4:0]  ev_lv1_q;
    logic [3:0]  nhits_q;
    logic [3:0]  hit_q;

    logic [14:0] q_rdata;
    logic        q_full;
    logic        q_empty;
    logic        q_pop;
    logic        q_push;
    logic        drop_inc;
    logic        pop_out;
    logic        gnt_trig;
    logic        gnt_rd;
    logic [3:0]  hits_eff;
    logic [6:0]  hit_col;
    logic [8:0]  hit_row;
    state_e      end_st;

    assign pop_out  = rec.read_fifo && valid_q;
    assign q_pop    = (state_q == ST_HDR) && pop_out && !ecr;
    assign q_push   = trigger && !ecr && (!q_full || q_pop);
    assign drop_inc = trigger && !ecr && !q_push;

    // Round-robin: on contention, serve whoever was not served last.
    assign gnt_trig = !q_empty && !ecr && (!rd_pend_q || last_rd_q);
    assign gnt_rd   = rd_pend_q && !gnt_trig;

    assign hits_eff = (cfg_hits_per_trig > MAX_H) ? MAX_H : cfg_hits_per_trig;
    assign hit_col  = {3'd0, hit_q} + 7'd1;
    assign hit_row  = {4'd0, ev_lv1_q} + 9'd1;

    assign rec.empty     = !valid_q;
    assign rec.data      = data_q;
    assign trig_drop_cnt = drop_q;

    fei4_trig_queue #(
        .DEPTH (TRIG_DEPTH),
        .W     (15)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (ecr),
        .wdata_i ({lv1_q, bcid_q}),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        end_st = ST_IDLE;
`ifdef SERVICE_REC_EN
        if (drop_q != '0) end_st = ST_SRV;
`endif
    end

    always_comb begin
        drop_d = drop_q;
`ifdef SERVICE_REC_EN
        if (state_q == ST_SRV && pop_out) drop_d = '0;
`endif
        if (drop_inc && drop_d != 10'd1023) drop_d = drop_d + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcid_q <= '0;
            lv1_q  <= '0;
            drop_q <= '0;
        end else begin
            bcid_q <= bcr ? '0 : bcid_q + 10'd1;
            drop_q <= drop_d;
            if (ecr)          lv1_q <= '0;
            else if (trigger) lv1_q <= lv1_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else if (rd_req) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= rd_addr;
            rd_data_q <= rd_data;
        end else if (state_q == ST_VAL && pop_out) begin
            rd_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_rd_q <= 1'b1;
            ev_lv1_q  <= '0;
            nhits_q   <= '0;
            hit_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_trig) begin
                        data_q    <= {HDR_DH, 1'b0, q_rdata};
                        valid_q   <= 1'b1;
                        ev_lv1_q  <= q_rdata[14:10];
                        last_rd_q <= 1'b0;
                        state_q   <= ST_HDR;
                    end else if (gnt_rd) begin
                        data_q    <= {HDR_AR, 1'b0, 9'd0, rd_addr_q};
                        valid_q   <= 1'b1;
                        last_rd_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_HDR: begin
                    if (pop_out) begin
                        valid_q <= 1'b0;
                        nhits_q <= hits_eff;
                        hit_q   <= '0;
                        state_q <= (hits_eff != '0) ? ST_HIT : end_st;
                    end
                end
                ST_HIT: begin
                    if (!valid_q) begin
                        data_q  <= {hit_col, hit_row, cfg_tot, 4'hF};
                        valid_q <= 1'b1;
                    end else if (pop_out) begin
                        valid_q <= 1'b0;
                        hit_q   <= hit_q + 4'd1;
                        if (hit_q + 4'd1 == nhits_q) state_q <= end_st;
                    end
                end
                ST_ADDR: begin
                    if (pop_out) begin
                        valid_q <= 1'b0;
                        state_q <= ST_VAL;
                    end
                end
                ST_VAL: begin
                    if (!valid_q) begin
                        data_q  <= {HDR_VR, rd_data_q};
                        valid_q <= 1'b1;
                    end else if (pop_out) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
`ifdef SERVICE_REC_EN
                ST_SRV: begin
                    if (!valid_q) begin
                        data_q  <= {HDR_SR, SR_CODE_TRIG_DROP, drop_q};
                        valid_q <= 1'b1;
                    end else if (pop_out) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
            // ecr abandons an event but never a readback in flight.
            if (ecr && (state_q == ST_HDR || state_q == ST_HIT)) begin
                valid_q <= 1'b0;
                state_q <= ST_IDLE;
            end
        end
    end

endmodule
